// File: rtl/muldiv_hilo_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit and the control unit that drives it.
package muldiv_hilo_pkg;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  localparam int unsigned ITER_COUNT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_hilo.sv
// Iterative shift-add multiplier / restoring divider writing HI/LO, with MTHI/MTLO access.
// Multiply and divide share one 2*WIDTH working register and the iteration counter.
module muldiv_hilo
  import muldiv_hilo_pkg::*;
#(
  parameter int unsigned WIDTH = ITER_COUNT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam int unsigned ACC_W = 2 * WIDTH;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               busy_q, busy_d, done_q, done_d, dz_q, dz_d;

  logic [WIDTH-1:0]   mag_a_in, mag_b_in, mag_a_q, mag_b_q;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic               rem_fits;
  logic [WIDTH-1:0]   rem_diff;
  logic               neg_res;
  logic [WIDTH-1:0]   quot, rem;

  // Operand magnitudes: signed ops (op[0]=1) work on absolute values, sign fixed in FIX.
  assign mag_a_in = (op[0] && A[WIDTH-1]) ? -A : A;
  assign mag_b_in = (op[0] && B[WIDTH-1]) ? -B : B;
  assign mag_a_q  = (op_q[0] && a_q[WIDTH-1]) ? -a_q : a_q;
  assign mag_b_q  = (op_q[0] && b_q[WIDTH-1]) ? -b_q : b_q;

  // Multiply step: conditionally add multiplicand into upper half, then shift right with carry.
  assign mul_sum  = {1'b0, acc_q[ACC_W-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_a_q} : '0);

  // Divide step: shift partial remainder left one bit and try to subtract the divisor.
  assign rem_sh   = acc_q[ACC_W-1:WIDTH-1];
  assign rem_fits = (rem_sh >= {1'b0, mag_b_q});
  assign rem_diff = rem_sh[WIDTH-1:0] - mag_b_q;

  assign neg_res  = op_q[0] & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
  assign quot     = acc_q[WIDTH-1:0];
  assign rem      = acc_q[ACC_W-1:WIDTH];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dz_d    = dz_q;

    unique case (state_q)
      IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start) begin
          state_d = CALC;
          cnt_d   = '0;
          op_d    = op;
          a_d     = A;
          b_d     = B;
          dz_d    = 1'b0;
          acc_d   = {{WIDTH{1'b0}}, (op[1] ? mag_a_in : mag_b_in)};
        end
      end
      CALC: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (op_q[1]) begin
          acc_d = rem_fits ? {rem_diff, acc_q[WIDTH-2:0], 1'b1}
                           : {acc_q[ACC_W-2:0], 1'b0};
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = FIX;
          cnt_d   = '0;
        end
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (!op_q[1]) begin
          {hi_d, lo_d} = neg_res ? -acc_q : acc_q;
        end else if (b_q == '0) begin
          lo_d = '1;
          hi_d = a_q;
          dz_d = 1'b1;
        end else begin
          lo_d = neg_res ? -quot : quot;
          hi_d = (op_q[0] && a_q[WIDTH-1]) ? -rem : rem;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_hilo.sv
// Scoreboard bench for muldiv_hilo: reference results are queued at start and checked on done.
module tb_muldiv_hilo;
  import muldiv_hilo_pkg::*;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wdata = '0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t exp_q[$];

  muldiv_hilo #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .A(A), .B(B),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [63:0] up;
    logic signed [63:0] sp;
    logic signed [31:0] sa, sb;
    e = '0;
    sa = a;
    sb = b;
    if (o == OP_MULTU) begin
      up = {32'b0, a} * {32'b0, b};
      {e.hi, e.lo} = up;
    end else if (o == OP_MULT) begin
      sp = 64'(sa) * 64'(sb);
      {e.hi, e.lo} = sp;
    end else if (b == 32'h0) begin
      e.lo = 32'hFFFF_FFFF;
      e.hi = a;
      e.dz = 1'b1;
    end else if (o == OP_DIVU) begin
      e.lo = a / b;
      e.hi = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.lo = 32'h8000_0000;
      e.hi = 32'h0;
    end else begin
      e.lo = 32'(sa / sb);
      e.hi = 32'(sa % sb);
    end
    return e;
  endfunction

  // Issues one op at the current cycle (cycle 0) and follows it to done; optionally re-pulses
  // start plus hi_we during busy, or writes HI together with start.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int repulse_cyc, input logic [31:0] mt_data, input bit mt_start);
    logic [31:0] hi_pre, lo_pre;
    exp_t        e;
    bit          seen;
    int          cyc;
    exp_q.push_back(model(o, a, b));
    hi_pre = mt_start ? mt_data : hi;
    lo_pre = lo;
    start = 1'b1; op = o; A = a; B = b;
    hi_we = mt_start; wdata = mt_data;
    seen = 1'b0;
    cyc = 0;
    while (!seen && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      start = 1'b0; hi_we = 1'b0;
      A = $urandom; B = $urandom; op = 2'($urandom);
      if (cyc == repulse_cyc) begin
        start = 1'b1; hi_we = 1'b1; wdata = mt_data;
      end
      if (cyc == 1) begin
        n_vec++;
        if (div_zero !== 1'b0) begin
          n_err++; $display("FAIL dz_clear_on_start: got %b want 0", div_zero);
        end
      end
      if (done === 1'b1) begin
        seen = 1'b1;
        n_vec++;
        if (cyc != 34) begin
          n_err++; $display("FAIL done_cycle: got %0d want 34", cyc);
        end
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL scoreboard_empty: unexpected done, got hi=%h lo=%h", hi, lo);
        end else begin
          e = exp_q.pop_front();
          n_vec += 3;
          if (hi !== e.hi) begin
            n_err++; $display("FAIL hi op=%0d a=%h b=%h: got %h want %h", o, a, b, hi, e.hi);
          end
          if (lo !== e.lo) begin
            n_err++; $display("FAIL lo op=%0d a=%h b=%h: got %h want %h", o, a, b, lo, e.lo);
          end
          if (div_zero !== e.dz) begin
            n_err++; $display("FAIL div_zero op=%0d b=%h: got %b want %b", o, b, div_zero, e.dz);
          end
        end
      end else begin
        n_vec++;
        if (busy !== (cyc <= 33)) begin
          n_err++; $display("FAIL busy cycle %0d: got %b want %b", cyc, busy, (cyc <= 33));
        end
        if (cyc <= 33) begin
          n_vec++;
          if (hi !== hi_pre || lo !== lo_pre) begin
            n_err++;
            $display("FAIL hilo_hold cycle %0d: got %h_%h want %h_%h", cyc, hi, lo, hi_pre, lo_pre);
          end
        end
      end
    end
    if (!seen) begin
      n_vec++; n_err++;
      $display("FAIL done_timeout: no done within 40 cycles, got busy=%b", busy);
    end
  endtask

  task automatic expect_quiet(input int cycles, input string name);
    int n_done;
    n_done = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) n_done++;
    end
    n_vec++;
    if (n_done != 0) begin
      n_err++; $display("FAIL %s: got %0d busy/done cycles want 0", name, n_done);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_vec += 5;
    if (busy !== 1'b0)     begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (done !== 1'b0)     begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    if (div_zero !== 1'b0) begin n_err++; $display("FAIL reset_dz: got %b want 0", div_zero); end
    if (hi !== 32'h0)      begin n_err++; $display("FAIL reset_hi: got %h want 0", hi); end
    if (lo !== 32'h0)      begin n_err++; $display("FAIL reset_lo: got %h want 0", lo); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_multiply();
    logic [31:0] a, b;
    run_op(OP_MULTU, 32'd15, 32'd20, 0, '0, 1'b0);
    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, 0, '0, 1'b0);
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, '0, 1'b0);
    run_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, 0, '0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      a = $urandom; b = $urandom;
      run_op((i % 2 == 0) ? OP_MULT : OP_MULTU, a, b, 0, '0, 1'b0);
    end
  endtask

  task automatic test_divide();
    logic [31:0] a, b;
    run_op(OP_DIVU, 32'd100, 32'd20, 0, '0, 1'b0);
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, '0, 1'b0);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, '0, 1'b0);
    run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, 0, '0, 1'b0);
    run_op(OP_DIVU, 32'hFFFF_FFFF, 32'd1, 0, '0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      a = $urandom;
      b = (i < 2) ? 32'($urandom_range(1, 1000)) : $urandom;
      run_op((i % 2 == 0) ? OP_DIV : OP_DIVU, a, b, 0, '0, 1'b0);
    end
  endtask

  task automatic test_div_zero();
    run_op(OP_DIVU, 32'd100, 32'd0, 0, '0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (div_zero !== 1'b1) begin
      n_err++; $display("FAIL dz_sticky: got %b want 1", div_zero);
    end
    run_op(OP_DIVU, 32'd100, 32'd20, 0, '0, 1'b0);
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd0, 0, '0, 1'b0);
  endtask

  task automatic test_ignore_start();
    run_op(OP_DIVU, 32'd100, 32'd20, 10, 32'h0000_DEAD, 1'b0);
    expect_quiet(40, "no_second_done");
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0000_BEEF;
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b0; wdata = 32'h0;
    n_vec += 2;
    if (hi !== 32'h0000_BEEF) begin n_err++; $display("FAIL mthi: got %h want 0000beef", hi); end
    if (lo !== 32'h0000_BEEF) begin n_err++; $display("FAIL mtlo: got %h want 0000beef", lo); end
  endtask

  task automatic test_back_to_back();
    run_op(OP_MULTU, 32'd1234, 32'd5678, 0, '0, 1'b0);
    run_op(OP_DIV, 32'hFFFF_FF00, 32'd3, 0, 32'h1234_5678, 1'b1);
    run_op(OP_MULT, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 0, '0, 1'b0);
  endtask

  task automatic test_async_reset();
    start = 1'b1; op = OP_MULT; A = 32'hFFFF_0001; B = 32'h0001_0003;
    for (int c = 1; c <= 15; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec += 4;
    if (busy !== 1'b0)  begin n_err++; $display("FAIL arst_busy: got %b want 0", busy); end
    if (done !== 1'b0)  begin n_err++; $display("FAIL arst_done: got %b want 0", done); end
    if (hi !== 32'h0)   begin n_err++; $display("FAIL arst_hi: got %h want 0", hi); end
    if (lo !== 32'h0)   begin n_err++; $display("FAIL arst_lo: got %h want 0", lo); end
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    expect_quiet(40, "no_done_after_reset");
    run_op(OP_MULTU, 32'd15, 32'd20, 0, '0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_multiply();
    test_divide();
    test_div_zero();
    test_ignore_start();
    test_back_to_back();
    test_async_reset();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
